// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [63:0] PC_STEP          = 64'd4;

  // One fetched instruction as handed to decode.
  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
  } fetch_data_t;

  // Output-side entry: fetch data plus the misaligned-fetch flag.
  typedef struct packed {
    logic        exc;
    fetch_data_t data;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_ADDR,
    S_DATA,
    S_HOLD,
    S_DROP
  } fetch_state_t;

  // Sequential PC advance; wraps modulo 2^64.
  function automatic logic [63:0] pc_next(input logic [63:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_skid.sv
// Output register plus one-entry stash for the fetch stage.
// A push goes straight to the output register when it is empty or being
// drained this cycle; otherwise it lands in the stash. The stash refills the
// output register as soon as decode accepts. Flush empties both.
// The producer must only push while the stash is empty.
module fetch_stage_skid
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  fetch_entry_t in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output fetch_entry_t out_data
);

  logic         out_valid_q, out_valid_d;
  logic         stash_valid_q, stash_valid_d;
  fetch_entry_t out_q, out_d;
  fetch_entry_t stash_q, stash_d;

  // Next-state for output register and stash; flush overrides any load.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_d         = out_q;
    stash_valid_d = stash_valid_q;
    stash_d       = stash_q;
    if (flush) begin
      out_valid_d   = 1'b0;
      stash_valid_d = 1'b0;
    end else if (stash_valid_q) begin
      if (out_ready) begin
        out_d         = stash_q;
        out_valid_d   = 1'b1;
        stash_valid_d = 1'b0;
      end
    end else if (in_valid) begin
      if (!out_valid_q || out_ready) begin
        out_d       = in_data;
        out_valid_d = 1'b1;
      end else begin
        stash_d       = in_data;
        stash_valid_d = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Register state; reset clears the visible output data as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_q         <= '0;
      stash_valid_q <= 1'b0;
      stash_q       <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_q         <= out_d;
      stash_valid_q <= stash_valid_d;
      stash_q       <= stash_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the instruction bus, returns {raw_instr, pc}
// to decode over valid/ready, and discards responses made stale by a redirect.
// Optional feature FETCH_MISALIGN_EN: a misaligned PC raises out_exc instead
// of fetching; when undefined, redirect targets are forced word-aligned.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [95:0] out_data,
  input  logic        out_ready,
  output logic        out_exc
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  req_addr_q, req_addr_d;
  logic         kill_q, kill_d;
  logic [63:0]  redir_pc;
  logic         req_live;
  logic         direct;
  logic         take;
  logic         push;
  fetch_entry_t push_entry;
  logic         skid_out_valid;
  fetch_entry_t out_entry;

`ifdef FETCH_MISALIGN_EN
  logic misalign;
  logic park_q, park_d;

  assign redir_pc = redirect_pc;
  assign misalign = (req_addr_q[1:0] != 2'b00);
  assign req_live = (state_q == S_ADDR) && !misalign;
`else
  assign redir_pc = redirect_pc & ~64'h3;
  assign req_live = (state_q == S_ADDR);
`endif

  // A response can go straight to decode when the output slot is free or draining.
  assign direct = !skid_out_valid || out_ready;

  // FSM next state, PC update, kill tracking and skid push.
  // req_addr is frozen while an unaccepted request is on the bus so a
  // redirect cannot change it mid-handshake; otherwise it follows pc_d.
  always_comb begin
    state_d                   = state_q;
    pc_d                      = pc_q;
    kill_d                    = kill_q;
    take                      = 1'b0;
    push                      = 1'b0;
    push_entry.exc            = 1'b0;
    push_entry.data.raw_instr = iresp_data;
    push_entry.data.pc        = pc_q;
`ifdef FETCH_MISALIGN_EN
    park_d                    = park_q;
`endif
    unique case (state_q)
      S_ADDR: begin
`ifdef FETCH_MISALIGN_EN
        if (misalign) begin
          if (redirect_valid) begin
            pc_d = redir_pc;
          end else begin
            push                      = 1'b1;
            push_entry.exc            = 1'b1;
            push_entry.data.raw_instr = '0;
            state_d                   = S_HOLD;
            park_d                    = 1'b1;
          end
        end else
`endif
        if (redirect_valid) begin
          pc_d = redir_pc;
          if (iresp_addr_ok && iresp_data_ok) begin
            state_d = S_ADDR;
            kill_d  = 1'b0;
          end else if (iresp_addr_ok) begin
            state_d = S_DROP;
            kill_d  = 1'b1;
          end else begin
            kill_d = 1'b1;
          end
        end else if (iresp_addr_ok) begin
          if (kill_q) begin
            if (iresp_data_ok) begin
              state_d = S_ADDR;
              kill_d  = 1'b0;
            end else begin
              state_d = S_DROP;
            end
          end else if (iresp_data_ok) begin
            take = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          kill_d  = !iresp_data_ok;
          state_d = iresp_data_ok ? S_ADDR : S_DROP;
        end else if (iresp_data_ok) begin
          take = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = S_ADDR;
          kill_d  = 1'b0;
`ifdef FETCH_MISALIGN_EN
          park_d  = 1'b0;
        end else if (out_ready && !park_q) begin
`else
        end else if (out_ready) begin
`endif
          pc_d    = pc_next(pc_q);
          state_d = S_ADDR;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
        end
        if (iresp_data_ok) begin
          state_d = S_ADDR;
          kill_d  = 1'b0;
        end
      end
      default: state_d = S_ADDR;
    endcase
    if (take) begin
      push = 1'b1;
      if (direct) begin
        pc_d    = pc_next(pc_q);
        state_d = S_ADDR;
      end else begin
        state_d = S_HOLD;
      end
    end
    req_addr_d = (req_live && !iresp_addr_ok) ? req_addr_q : pc_d;
  end

  // FSM, PC and request-address registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_ADDR;
      pc_q       <= PC_RESET;
      req_addr_q <= PC_RESET;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
    end
  end

`ifdef FETCH_MISALIGN_EN
  // Park flag: stage waits for a redirect after reporting a misaligned PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      park_q <= 1'b0;
    end else begin
      park_q <= park_d;
    end
  end
`endif

  fetch_stage_skid u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (redirect_valid),
    .in_valid  (push),
    .in_data   (push_entry),
    .out_ready (out_ready),
    .out_valid (skid_out_valid),
    .out_data  (out_entry)
  );

  // Bus request is suppressed combinationally while reset is asserted.
  assign ireq_valid = reset && req_live;
  assign ireq_addr  = ireq_valid ? req_addr_q : '0;
  assign out_valid  = skid_out_valid;
  assign out_data   = out_entry.data;
  assign out_exc    = out_entry.exc;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by a randomized
// bus/decode/redirect phase checked against a stream-level PC model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [95:0] out_data;
  logic        out_ready;
  logic        out_exc;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.PC_RESET(64'h0000_0000_8000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .out_exc        (out_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction word the modelled memory holds at a given address.
  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA5A5_0F0F;
  endfunction

  task automatic drive(input logic aok, input logic dok, input logic [31:0] d,
                       input logic rv, input logic [63:0] rpc);
    iresp_addr_ok  = aok;
    iresp_data_ok  = dok;
    iresp_data     = d;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    repeat (2) @(negedge clk);
    check("rst_ireq_valid", ireq_valid, 1'b0);
    check("rst_ireq_addr", ireq_addr, 64'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 96'h0);
    check("rst_out_exc", out_exc, 1'b0);
    reset = 1'b1;
    #1;
  endtask

  logic [63:0] exp_pc;
  logic [63:0] pend_addr;
  logic [63:0] prev_addr;
  logic [63:0] tgt;
  logic        pending;
  logic        prev_wait;
  logic        aok, dok, rdy, rv;
  logic [31:0] d;
  int unsigned cnt;
  int unsigned dl;
  int          transfers;

  initial begin
    reset = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);

    // 1: same-cycle addr_ok+data_ok right after reset
    do_reset();
    check("t1_req_valid", ireq_valid, 1'b1);
    check("t1_req_addr", ireq_addr, 64'h8000_0000);
    check("t1_out_idle", out_valid, 1'b0);
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 32'h0010_0093, 1'b0, 64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_out_data", out_data, {32'h0010_0093, 64'h8000_0000});
    check("t1_out_exc", out_exc, 1'b0);
    check("t1_next_addr", ireq_addr, 64'h8000_0004);

    // 2: decode stalls with two responses; second is held, no third request
    do_reset();
    drive(1'b1, 1'b1, 32'h1111_1111, 1'b0, 64'h0);
    @(negedge clk);
    check("t2_first_out", out_data, {32'h1111_1111, 64'h8000_0000});
    check("t2_second_addr", ireq_addr, 64'h8000_0004);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 64'h0);
    @(negedge clk);
    check("t2_wait_noreq", ireq_valid, 1'b0);
    drive(1'b0, 1'b1, 32'h2222_2222, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
      check("t2_hold_noreq", ireq_valid, 1'b0);
      check("t2_hold_out", out_data, {32'h1111_1111, 64'h8000_0000});
      check("t2_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t2_second_out_valid", out_valid, 1'b1);
    check("t2_second_out", out_data, {32'h2222_2222, 64'h8000_0004});
    check("t2_third_req", ireq_addr, 64'h8000_0008);
    // asynchronous reset mid-operation
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t2_async_out_valid", out_valid, 1'b0);
    check("t2_async_req_valid", ireq_valid, 1'b0);
    check("t2_async_req_addr", ireq_addr, 64'h0);

    // 3: redirect in S_DATA, stale response three cycles later
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 64'h0);
    @(negedge clk);
    check("t3_in_data_noreq", ireq_valid, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_1000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
      check("t3_drop_noreq", ireq_valid, 1'b0);
      check("t3_drop_noout", out_valid, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0);
    check("t3_drop_noreq2", ireq_valid, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    check("t3_stale_dropped", out_valid, 1'b0);
    check("t3_new_req_valid", ireq_valid, 1'b1);
    check("t3_new_req_addr", ireq_addr, 64'h8000_1000);
    drive(1'b1, 1'b1, 32'h00A0_0513, 1'b0, 64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    check("t3_target_out", out_data, {32'h00A0_0513, 64'h8000_1000});

    // 4: redirect while the request is not yet accepted
    do_reset();
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 64'h8000_2000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
      check("t4_req_held_valid", ireq_valid, 1'b1);
      check("t4_req_held_addr", ireq_addr, 64'h8000_0000);
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 64'h0);
    @(negedge clk);
    check("t4_drop_noreq", ireq_valid, 1'b0);
    drive(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    check("t4_stale_dropped", out_valid, 1'b0);
    check("t4_new_req_addr", ireq_addr, 64'h8000_2000);
    drive(1'b1, 1'b1, 32'h0000_0013, 1'b0, 64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    check("t4_target_out", out_data, {32'h0000_0013, 64'h8000_2000});

    // 5: PC wrap at the top of the address space
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 32'hCAFE_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    check("t5_coincident_dropped", out_valid, 1'b0);
    check("t5_req_top", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b1, 1'b1, 32'h0000_0073, 1'b0, 64'h0);
    @(negedge clk);
    check("t5_out_top", out_data, {32'h0000_0073, 64'hFFFF_FFFF_FFFF_FFFC});
    check("t5_req_wrap", ireq_addr, 64'h0);
    drive(1'b1, 1'b1, 32'h0010_0113, 1'b0, 64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    check("t5_out_wrap", out_data, {32'h0010_0113, 64'h0});

    // 6: misaligned redirect target
    do_reset();
    drive(1'b1, 1'b1, 32'h1234_5678, 1'b1, 64'h8000_0002);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
`ifdef FETCH_MISALIGN_EN
    check("t6_no_req", ireq_valid, 1'b0);
    @(negedge clk);
    check("t6_no_req2", ireq_valid, 1'b0);
    check("t6_exc_valid", out_valid, 1'b1);
    check("t6_exc_flag", out_exc, 1'b1);
    check("t6_exc_data", out_data, {32'h0, 64'h8000_0002});
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_parked_noreq", ireq_valid, 1'b0);
      check("t6_parked_noout", out_valid, 1'b0);
    end
`else
    check("t6_aligned_req_valid", ireq_valid, 1'b1);
    check("t6_aligned_req_addr", ireq_addr, 64'h8000_0000);
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_0013, 1'b0, 64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    check("t6_aligned_out", out_data, {32'h0000_0013, 64'h8000_0000});
    check("t6_no_exc", out_exc, 1'b0);
`endif

    // Randomized phase: random bus latency, decode stalls and redirects.
    // Expected output is the sequential PC stream restarted at each redirect.
    do_reset();
    exp_pc    = 64'h8000_0000;
    pending   = 1'b0;
    prev_wait = 1'b0;
    prev_addr = 64'h0;
    pend_addr = 64'h0;
    cnt       = 0;
    transfers = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_wait) begin
        check("rnd_req_hold_valid", ireq_valid, 1'b1);
        check("rnd_req_hold_addr", ireq_addr, prev_addr);
      end
      aok = 1'b0;
      dok = 1'b0;
      d   = 32'h0;
      if (pending) begin
        check("rnd_one_outstanding", ireq_valid, 1'b0);
        if (cnt == 0) begin
          dok     = 1'b1;
          d       = word_of(pend_addr);
          pending = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end else if (ireq_valid && $urandom_range(3) != 0) begin
        aok = 1'b1;
        dl  = $urandom_range(3);
        if (dl == 0) begin
          dok = 1'b1;
          d   = word_of(ireq_addr);
        end else begin
          pending   = 1'b1;
          pend_addr = ireq_addr;
          cnt       = dl - 1;
        end
      end
      prev_wait = ireq_valid && !aok;
      prev_addr = ireq_addr;
      rdy = ($urandom_range(3) != 0);
      rv  = ($urandom_range(15) == 0);
      tgt = {$urandom, $urandom};
`ifdef FETCH_MISALIGN_EN
      tgt[1:0] = 2'b00;
`endif
      if (out_valid && rdy) begin
        check("rnd_out_data", out_data, {word_of(exp_pc), exp_pc});
        check("rnd_out_exc", out_exc, 1'b0);
        exp_pc = exp_pc + 64'd4;
        transfers++;
      end
      if (rv) begin
        exp_pc = {tgt[63:2], 2'b00};
      end
      drive(aok, dok, d, rv, tgt);
      out_ready = rdy;
      @(negedge clk);
    end
    check("rnd_progress", (transfers > 200), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
